// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// States, frame widths and line levels used by tx_block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and wraps.
// bit_end marks the final cycle of each serial bit.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    logic [7:0] count;

    assign bit_end = (count == 8'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= bit_end ? '0 : count + 8'd1;
        end
    end

endmodule

// File: rtl/tx_block.sv
// UART transmitter with one-entry holding buffer and sticky overrun flag.
// Define TX_PARITY_EN to add an even-parity bit between data and stop.
module tx_block
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       data_write,
    input  logic [7:0] tx_data,
    input  logic       err_clear,
    output logic       serial_out,
    output logic       buffer_full,
    output logic       busy,
    output logic       tx_done,
    output logic       overrun_error
);

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] buffer;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [2:0]           bit_idx;
    logic                 bit_end;
    logic                 load;
    logic                 accept;
    logic                 full_n;
    logic                 out_n;
    logic                 done_n;
    logic                 parity_q;

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .en     (state != IDLE),
        .clr    (load),
        .bit_end(bit_end)
    );

    assign load   = buffer_full &&
                    (state == IDLE || (state == STOP && bit_end));
    assign accept = data_write && (!buffer_full || load);
    assign full_n = accept ? 1'b1 : (load ? 1'b0 : buffer_full);

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            IDLE:  if (load) state_n = START;
            START: if (bit_end) state_n = DATA;
            DATA: begin
                if (bit_end && bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef TX_PARITY_EN
            PARITY: if (bit_end) state_n = STOP;
`endif
            STOP: begin
                if (bit_end) begin
                    done_n  = 1'b1;
                    state_n = buffer_full ? START : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line level is computed from the next state so serial_out is a flop.
    always_comb begin
        shift_n = shift;
        if (load) begin
            shift_n = buffer;
        end else if (state == DATA && bit_end) begin
            shift_n = {1'b0, shift[DATA_BITS-1:1]};
        end
        case (state_n)
            IDLE:   out_n = IDLE_LEVEL;
            START:  out_n = START_LEVEL;
            DATA:   out_n = shift_n[0];
`ifdef TX_PARITY_EN
            PARITY: out_n = parity_q;
`endif
            STOP:   out_n = STOP_LEVEL;
            default: out_n = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= IDLE;
            serial_out    <= IDLE_LEVEL;
            buffer_full   <= 1'b0;
            busy          <= 1'b0;
            tx_done       <= 1'b0;
            overrun_error <= 1'b0;
            bit_idx       <= '0;
        end else begin
            state       <= state_n;
            serial_out  <= out_n;
            buffer_full <= full_n;
            busy        <= (state_n != IDLE) | full_n;
            tx_done     <= done_n;
            if (data_write && !accept) begin
                overrun_error <= 1'b1;
            end else if (err_clear) begin
                overrun_error <= 1'b0;
            end
            if (state == DATA && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) buffer <= tx_data;
        shift <= shift_n;
    end

`ifdef TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (load) parity_q <= ^buffer;
    end
`else
    assign parity_q = 1'b0;
`endif

endmodule

// File: tb/tb_tx_block.sv
// Scoreboard bench for tx_block: stimulus queues expected bytes,
// a serial monitor decodes each frame and compares against the queue.
module tb_tx_block;

    localparam int CPB = 10;
`ifdef TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME = BITS * CPB;
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       data_write;
    logic [7:0] tx_data;
    logic       err_clear;
    logic       serial_out;
    logic       buffer_full;
    logic       busy;
    logic       tx_done;
    logic       overrun_error;

    int passed = 0;
    int total  = 0;

    logic [8:0] q[$];

    int         off = -1;
    logic [7:0] mb;
    logic       mp;
    logic [8:0] exp_e;

    tx_block #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .data_write   (data_write),
        .tx_data      (tx_data),
        .err_clear    (err_clear),
        .serial_out   (serial_out),
        .buffer_full  (buffer_full),
        .busy         (busy),
        .tx_done      (tx_done),
        .overrun_error(overrun_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Serial monitor: offset 0 is the first sample with the line low.
    always @(negedge clk) begin
        if (!n_rst) begin
            off = -1;
        end else if (off < 0) begin
            if (serial_out === 1'b0) off = 0;
        end else begin
            off++;
        end
        if (off > 0) begin
            if (off == CPB / 2) chk("start_bit", serial_out, 0);
            if (off >= CPB && off < 9 * CPB && off % CPB == CPB / 2)
                mb[off / CPB - 1] = serial_out;
            if (BITS == 11 && off == 9 * CPB + CPB / 2) mp = serial_out;
            if (off == (BITS - 1) * CPB + CPB / 2) begin
                chk("stop_bit", serial_out, 1);
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL frame_unexpected: got %0h expected none", mb);
                end else begin
                    exp_e = q.pop_front();
                    chk("frame_byte", mb, exp_e[7:0]);
                    if (BITS == 11) chk("parity_bit", mp, exp_e[8]);
                end
            end
            if (off == FRAME - 1) chk("tx_done_early", tx_done, 0);
            if (off == FRAME) begin
                chk("tx_done_end", tx_done, 1);
                off = (serial_out === 1'b0) ? 0 : -1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        data_write = 1'b1;
        tx_data    = d;
        @(negedge clk);
        data_write = 1'b0;
        tx_data    = 8'h00;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!tx_done && c < LIMIT);
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while ((q.size() != 0 || busy) && c < LIMIT) begin
            @(negedge clk);
            c++;
        end
        chk(name, (c < LIMIT), 1);
        cyc(3);
    endtask

    initial begin
        int c;
        n_rst      = 1'b0;
        data_write = 1'b0;
        tx_data    = 8'h00;
        err_clear  = 1'b0;
        cyc(3);
        chk("rst_serial", serial_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", buffer_full, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_ovr", overrun_error, 0);
        n_rst = 1'b1;
        cyc(2);

        // single frame 0xA5
        q.push_back({1'b0, 8'hA5});
        wr(8'hA5);
        chk("lat_e0_serial", serial_out, 1);
        chk("lat_e0_full", buffer_full, 1);
        chk("lat_e0_busy", busy, 1);
        @(negedge clk);
        chk("lat_e1_serial", serial_out, 0);
        chk("lat_e1_full", buffer_full, 0);
        wait_done(c);
        chk("frame_len", c, FRAME);
        chk("busy_falls", busy, 0);
        @(negedge clk);
        chk("done_pulse_1cyc", tx_done, 0);
        wait_idle("idle_a5");

        // back-to-back 0x3C then 0xFF
        q.push_back({1'b0, 8'h3C});
        wr(8'h3C);
        cyc(30);
        q.push_back({1'b0, 8'hFF});
        wr(8'hFF);
        chk("b2b_full", buffer_full, 1);
        wait_done(c);
        chk("b2b_no_gap", serial_out, 0);
        wait_done(c);
        chk("b2b_spacing", c, FRAME);
        wait_idle("idle_b2b");

        // overrun
        q.push_back({1'b0, 8'h11});
        q.push_back({1'b0, 8'h22});
        data_write = 1'b1;
        tx_data    = 8'h11;
        @(negedge clk);
        tx_data = 8'h22;
        @(negedge clk);
        tx_data = 8'h33;
        @(negedge clk);
        data_write = 1'b0;
        chk("ovr_set", overrun_error, 1);
        chk("ovr_full", buffer_full, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("ovr_clear", overrun_error, 0);
        err_clear = 1'b1;
        wr(8'h44);
        err_clear = 1'b0;
        chk("ovr_set_wins", overrun_error, 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("ovr_clear2", overrun_error, 0);
        wait_idle("idle_ovr");

        // write on the last STOP cycle with buffer full
        q.push_back({1'b1, 8'h07});
        q.push_back({1'b0, 8'h5A});
        q.push_back({1'b0, 8'h81});
        wr(8'h07);
        @(negedge clk);
        cyc(30);
        wr(8'h5A);
        cyc(FRAME - 1 - 31);
        data_write = 1'b1;
        tx_data    = 8'h81;
        @(negedge clk);
        data_write = 1'b0;
        tx_data    = 8'h00;
        chk("same_edge_done", tx_done, 1);
        chk("same_edge_full", buffer_full, 1);
        chk("same_edge_ovr", overrun_error, 0);
        chk("same_edge_start", serial_out, 0);
        wait_idle("idle_same");

        // reset in the middle of a frame
        q.push_back({1'b0, 8'h99});
        wr(8'h99);
        cyc(10);
        wr(8'h66);
        cyc(3);
        wr(8'h55);
        chk("pre_rst_ovr", overrun_error, 1);
        cyc(7);
        n_rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mid_rst_serial", serial_out, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovr", overrun_error, 0);
        chk("mid_rst_full", buffer_full, 0);
        cyc(2);
        n_rst = 1'b1;
        cyc(30);
        chk("post_rst_line", serial_out, 1);
        chk("post_rst_busy", busy, 0);
        q.push_back({1'b0, 8'hC3});
        wr(8'hC3);
        wait_idle("idle_recover");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
